stoch_signed_pool_stream: RTL

//  Spatially parallel signed stochastic pooling (max or average) over a CHANNELS x IM_HEIGHT x IM_WIDTH

---
 rtl/stoch_pool_pkg.sv | 39 +++
 rtl/stoch_signed_pool_stream_if.sv | 34 +++
 rtl/stoch_signed_win_reduce.sv | 167 ++++++++++++++++
 rtl/stoch_signed_pool_stream.sv | 95 +++++++++
 4 files changed

// File: rtl/stoch_pool_pkg.sv
// ----------------------------------------------------------------------------
// stoch_pool_pkg
// Shared types and helpers for the signed stochastic pooling stream.
//   pool_mode_e  : pooling reduction selector (POOL_MAX / POOL_AVG)
//   pool_out_dim : output extent of one pooled axis (floor division)
//   sat_add      : symmetric saturating add for signed counters of width w,
//                  clamps to +/-(2^(w-1)-1)
// No ports (package).
// ----------------------------------------------------------------------------
package stoch_pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    function automatic int pool_out_dim(input int im, input int k, input int p, input int s);
        return (im + 2 * p - k) / s + 1;
    endfunction

    // Operands are sign-extended to 32 bits by the caller; the result fits in
    // w bits and is truncated back by the caller.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int                 w);
        logic signed [31:0] s;
        logic signed [31:0] lim;
        s   = a + b;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/stoch_signed_pool_stream_if.sv
// ----------------------------------------------------------------------------
// stoch_signed_pool_stream_if
// Stream bundle between a stochastic producer and the pooling block.
//   clr       : synchronous restart of all pooling state
//   mode      : 0 = POOL_MAX, 1 = POOL_AVG
//   in_valid  : x_p/x_m carry a bit-step this cycle
//   x_p, x_m  : IN_BITS input rails, bit ((h*IM_WIDTH+w)*CHANNELS+c)
//   out_valid : y_p/y_m carry a bit-step
//   y_p, y_m  : OUT_BITS output rails, bit ((oh*OUT_W+ow)*CHANNELS+c)
// Modports: master = producer/testbench side, slave = pooling block side.
// ----------------------------------------------------------------------------
interface stoch_signed_pool_stream_if #(
    parameter int IN_BITS  = 432,
    parameter int OUT_BITS = 432
);
    logic                clr;
    logic                mode;
    logic                in_valid;
    logic [IN_BITS-1:0]  x_p;
    logic [IN_BITS-1:0]  x_m;
    logic                out_valid;
    logic [OUT_BITS-1:0] y_p;
    logic [OUT_BITS-1:0] y_m;

    modport master (
        output clr, mode, in_valid, x_p, x_m,
        input  out_valid, y_p, y_m
    );

    modport slave (
        input  clr, mode, in_valid, x_p, x_m,
        output out_valid, y_p, y_m
    );
endinterface

// File: rtl/stoch_signed_win_reduce.sv
// ----------------------------------------------------------------------------
// stoch_signed_win_reduce
// Reduces one N-tap window of dual-rail signed bitstreams to one dual-rail
// output bit per valid step.
//   MAX: per-tap saturating signed counters; output follows the tap with the
//        largest count before this step's update (lowest index on ties).
//   AVG: signed accumulator emitting +1/-1 whenever it reaches +/-N
//        (only built when STOCH_POOL_AVG_EN is defined; otherwise mode is
//        ignored and MAX is always used).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous restart, overrides in_valid
//   mode          : 0 = MAX, 1 = AVG
//   in_valid      : tap rails valid this cycle
//   tap_p, tap_m  : N tap rails (padding taps tied to 0 by the caller)
//   y_p, y_m      : registered output rails, 0 unless the previous cycle was
//                   a valid, non-cleared step
// ----------------------------------------------------------------------------
module stoch_signed_win_reduce
    import stoch_pool_pkg::*;
#(
    parameter int N     = 9,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         mode,
    input  logic         in_valid,
    input  logic [N-1:0] tap_p,
    input  logic [N-1:0] tap_m,
    output logic         y_p,
    output logic         y_m
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic signed [CNT_W-1:0] cnt_p1  [N];
    logic signed [CNT_W-1:0] cnt_nxt_p0 [N];
    logic signed [1:0]       v_p0    [N];
    logic signed [CNT_W-1:0] best_p0;
    logic [SEL_W-1:0]        sel_p0;
    logic                    max_yp_p0;
    logic                    max_ym_p0;
    logic                    yp_nxt_p0;
    logic                    ym_nxt_p0;
    logic                    upd_max_p0;

    // ---- stage p0: tap decode, argmax, next-state ----
    always_comb begin
        for (int i = 0; i < N; i++) begin
            v_p0[i] = 2'sb00;
            if (tap_p[i] && !tap_m[i]) begin
                v_p0[i] = 2'sb01;
            end else if (tap_m[i] && !tap_p[i]) begin
                v_p0[i] = 2'sb11;
            end
        end
    end

    // Strict '>' keeps the lowest index on ties, so all-zero counts pick tap 0.
    always_comb begin
        sel_p0  = '0;
        best_p0 = cnt_p1[0];
        for (int i = 1; i < N; i++) begin
            if (cnt_p1[i] > best_p0) begin
                best_p0 = cnt_p1[i];
                sel_p0  = SEL_W'(i);
            end
        end
    end

    // Output carries the selected tap's value, so p=m=1 collapses to 0.
    always_comb begin
        max_yp_p0 = tap_p[sel_p0] & ~tap_m[sel_p0];
        max_ym_p0 = tap_m[sel_p0] & ~tap_p[sel_p0];
        for (int i = 0; i < N; i++) begin
            cnt_nxt_p0[i] = CNT_W'(sat_add(32'(cnt_p1[i]), 32'(v_p0[i]), CNT_W));
        end
    end

`ifdef STOCH_POOL_AVG_EN
    localparam int ACC_W = CNT_W + $clog2(N) + 1;

    logic signed [ACC_W-1:0] acc_p1;
    logic signed [ACC_W-1:0] acc_nxt_p0;
    logic signed [31:0]      a_p0;
    logic signed [31:0]      acc_adj_p0;
    logic                    avg_yp_p0;
    logic                    avg_ym_p0;
    logic                    is_avg_p0;

    assign is_avg_p0 = (pool_mode_e'(mode) == POOL_AVG);

    always_comb begin
        a_p0 = 32'(acc_p1);
        for (int i = 0; i < N; i++) begin
            a_p0 = a_p0 + 32'(v_p0[i]);
        end
        avg_yp_p0  = 1'b0;
        avg_ym_p0  = 1'b0;
        acc_adj_p0 = a_p0;
        if (a_p0 >= 32'(N)) begin
            avg_yp_p0  = 1'b1;
            acc_adj_p0 = a_p0 - 32'(N);
        end else if (a_p0 <= -32'(N)) begin
            avg_ym_p0  = 1'b1;
            acc_adj_p0 = a_p0 + 32'(N);
        end
        acc_nxt_p0 = ACC_W'(sat_add(acc_adj_p0, 32'sd0, ACC_W));
    end

    always_comb begin
        upd_max_p0 = ~is_avg_p0;
        yp_nxt_p0  = is_avg_p0 ? avg_yp_p0 : max_yp_p0;
        ym_nxt_p0  = is_avg_p0 ? avg_ym_p0 : max_ym_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
        end else if (clr) begin
            acc_p1 <= '0;
        end else if (in_valid && is_avg_p0) begin
            acc_p1 <= acc_nxt_p0;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        upd_max_p0 = 1'b1;
        yp_nxt_p0  = max_yp_p0;
        ym_nxt_p0  = max_ym_p0;
    end
`endif

    // ---- stage p1: counters and output registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt_p1[i] <= '0;
            end
            y_p <= 1'b0;
            y_m <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                cnt_p1[i] <= '0;
            end
            y_p <= 1'b0;
            y_m <= 1'b0;
        end else if (in_valid) begin
            if (upd_max_p0) begin
                for (int i = 0; i < N; i++) begin
                    cnt_p1[i] <= cnt_nxt_p0[i];
                end
            end
            y_p <= yp_nxt_p0;
            y_m <= ym_nxt_p0;
        end else begin
            y_p <= 1'b0;
            y_m <= 1'b0;
        end
    end

endmodule

// File: rtl/stoch_signed_pool_stream.sv
// ----------------------------------------------------------------------------
// stoch_signed_pool_stream
// Spatially parallel signed stochastic pooling (max or average) over a
// CHANNELS x IM_HEIGHT x IM_WIDTH array of dual-rail bitstreams, one bit-step
// per valid cycle, latency 1.
// Optional feature macro: STOCH_POOL_AVG_EN builds the average datapath and
// honours mode; without it every window pools by max.
// Ports:
//   CLK   : clock
//   nRST  : asynchronous active-low reset
//   bus   : stoch_signed_pool_stream_if.slave (clr, mode, in_valid, x_p, x_m,
//           out_valid, y_p, y_m)
// ----------------------------------------------------------------------------
module stoch_signed_pool_stream
    import stoch_pool_pkg::*;
#(
    parameter int IM_HEIGHT = 12,
    parameter int IM_WIDTH  = 12,
    parameter int CHANNELS  = 3,
    parameter int KERNEL_H  = 3,
    parameter int KERNEL_W  = 3,
    parameter int PAD_H     = 1,
    parameter int PAD_W     = 1,
    parameter int STRIDE_H  = 1,
    parameter int STRIDE_W  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                      CLK,
    input  logic                      nRST,
    stoch_signed_pool_stream_if.slave bus
);

    localparam int OUT_H    = pool_out_dim(IM_HEIGHT, KERNEL_H, PAD_H, STRIDE_H);
    localparam int OUT_W    = pool_out_dim(IM_WIDTH, KERNEL_W, PAD_W, STRIDE_W);
    localparam int N        = KERNEL_H * KERNEL_W;
    localparam int OUT_BITS = OUT_H * OUT_W * CHANNELS;

    logic                vld_p1;
    logic [OUT_BITS-1:0] y_p_w;
    logic [OUT_BITS-1:0] y_m_w;

    // ---- stage p1: output valid ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid & ~bus.clr;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.y_p       = y_p_w;
    assign bus.y_m       = y_m_w;

    for (genvar oh = 0; oh < OUT_H; oh++) begin : g_oh
        for (genvar ow = 0; ow < OUT_W; ow++) begin : g_ow
            for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
                logic [N-1:0] tap_p;
                logic [N-1:0] tap_m;

                for (genvar kh = 0; kh < KERNEL_H; kh++) begin : g_kh
                    for (genvar kw = 0; kw < KERNEL_W; kw++) begin : g_kw
                        localparam int IH = oh * STRIDE_H - PAD_H + kh;
                        localparam int IW = ow * STRIDE_W - PAD_W + kw;
                        localparam int K  = kh * KERNEL_W + kw;
                        if (IH >= 0 && IH < IM_HEIGHT && IW >= 0 && IW < IM_WIDTH) begin : g_in
                            assign tap_p[K] = bus.x_p[(IH * IM_WIDTH + IW) * CHANNELS + c];
                            assign tap_m[K] = bus.x_m[(IH * IM_WIDTH + IW) * CHANNELS + c];
                        end else begin : g_pad
                            // Padding taps carry a constant zero value.
                            assign tap_p[K] = 1'b0;
                            assign tap_m[K] = 1'b0;
                        end
                    end
                end

                stoch_signed_win_reduce #(
                    .N     (N),
                    .CNT_W (CNT_W)
                ) u_win (
                    .clk      (CLK),
                    .rst_n    (nRST),
                    .clr      (bus.clr),
                    .mode     (bus.mode),
                    .in_valid (bus.in_valid),
                    .tap_p    (tap_p),
                    .tap_m    (tap_m),
                    .y_p      (y_p_w[(oh * OUT_W + ow) * CHANNELS + c]),
                    .y_m      (y_m_w[(oh * OUT_W + ow) * CHANNELS + c])
                );
            end
        end
    end

endmodule
